// File: rtl/memory_access_stage.sv
// Pipeline memory stage: issues loads/stores over a request/response data port,
// steers byte lanes, extends load data and registers the memory/writeback payload.
module memory_access_stage #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        executeMemoryPayloadValid,
  input  logic        executeMemoryPayloadIllegal,
  input  logic        executeMemoryPayloadMemoryReadEnable,
  input  logic        executeMemoryPayloadMemoryWriteEnable,
  input  logic [1:0]  executeMemoryPayloadMemoryWidth,
  input  logic        executeMemoryPayloadMemorySigned,
  input  logic [31:0] executeMemoryPayloadResult,
  input  logic [31:0] executeMemoryPayloadStoreData,
  input  logic [4:0]  executeMemoryPayloadDestinationRegister,
  input  logic [1:0]  executeMemoryPayloadWritebackType,
  input  logic [31:0] executeMemoryPayloadProgramCounter,
  input  logic [31:0] executeMemoryPayloadProgramCounterPlus4,
  input  logic [11:0] executeMemoryPayloadDestinationCSR,
  input  logic [31:0] executeMemoryPayloadOldCSRValue,
  input  logic [1:0]  executeMemoryPayloadCSROp,
  input  logic        executeMemoryPayloadCSRWriteIntent,
  input  logic        memoryWritebackControlStall,
  input  logic        memoryWritebackControlFlush,
  output logic        memoryStallRequest,
  output logic        dmemRequest,
  output logic        dmemWriteEnable,
  output logic [31:0] dmemAddress,
  output logic [31:0] dmemWriteData,
  output logic [3:0]  dmemByteEnable,
  input  logic        dmemGrant,
  input  logic        dmemResponseValid,
  input  logic [31:0] dmemReadData,
  output logic        memoryWritebackPayloadValid,
  output logic        memoryWritebackPayloadIllegal,
  output logic        memoryWritebackPayloadMemoryReadEnable,
  output logic        memoryWritebackPayloadMemoryWriteEnable,
  output logic [1:0]  memoryWritebackPayloadMemoryWidth,
  output logic        memoryWritebackPayloadMemorySigned,
  output logic [31:0] memoryWritebackPayloadResult,
  output logic [4:0]  memoryWritebackPayloadDestinationRegister,
  output logic [1:0]  memoryWritebackPayloadWritebackType,
  output logic [31:0] memoryWritebackPayloadProgramCounter,
  output logic [31:0] memoryWritebackPayloadProgramCounterPlus4,
  output logic [11:0] memoryWritebackPayloadDestinationCSR,
  output logic [31:0] memoryWritebackPayloadOldCSRValue,
  output logic [1:0]  memoryWritebackPayloadCSROp,
  output logic        memoryWritebackPayloadCSRWriteIntent,
  output logic        memoryWritebackPayloadException,
  output logic [3:0]  memoryWritebackPayloadExceptionCause,
  output logic [31:0] memoryWritebackPayloadTrapValue,
  output logic [1:0]  debug_state
);

  typedef enum logic [1:0] {IDLE, WAIT_RESP, HOLD, DRAIN} state_t;
  state_t state, state_next;

  logic        is_half, is_word, is_store;
  logic [1:0]  offset;
  logic        misaligned, mem_access, mem_op, misalign_exc;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext, load_data, out_result;
  logic        complete, capture, write_out;

  // Handshake: a request is accepted in any cycle where dmemRequest and
  // dmemGrant are both high; load data arrives later on dmemResponseValid.
  assign is_half      = (executeMemoryPayloadMemoryWidth == 2'd1);
  assign is_word      = executeMemoryPayloadMemoryWidth[1];
  assign is_store     = executeMemoryPayloadMemoryWriteEnable;
  assign offset       = executeMemoryPayloadResult[1:0];
  assign misaligned   = (is_half && offset[0]) || (is_word && (offset != 2'd0));
  assign mem_access   = executeMemoryPayloadValid && !executeMemoryPayloadIllegal &&
                        (executeMemoryPayloadMemoryReadEnable || executeMemoryPayloadMemoryWriteEnable);
  assign mem_op       = mem_access && !misaligned;
  assign misalign_exc = mem_access && misaligned;

  assign dmemAddress     = {executeMemoryPayloadResult[31:2], 2'b00};
  assign dmemWriteEnable = is_store;
  assign debug_state     = state;

  always_comb begin
    dmemWriteData  = executeMemoryPayloadStoreData;
    dmemByteEnable = 4'b1111;
    if (!is_word) begin
      if (is_half) begin
        dmemWriteData  = {2{executeMemoryPayloadStoreData[15:0]}};
        dmemByteEnable = 4'b0011 << offset;
      end else begin
        dmemWriteData  = {4{executeMemoryPayloadStoreData[7:0]}};
        dmemByteEnable = 4'b0001 << offset;
      end
    end
  end

  always_comb begin
    case (offset)
      2'd0:    rd_byte = dmemReadData[7:0];
      2'd1:    rd_byte = dmemReadData[15:8];
      2'd2:    rd_byte = dmemReadData[23:16];
      default: rd_byte = dmemReadData[31:24];
    endcase
    rd_half  = offset[1] ? dmemReadData[31:16] : dmemReadData[15:0];
    load_ext = dmemReadData;
    if (!is_word) begin
      if (is_half) load_ext = {{16{executeMemoryPayloadMemorySigned & rd_half[15]}}, rd_half};
      else         load_ext = {{24{executeMemoryPayloadMemorySigned & rd_byte[7]}}, rd_byte};
    end
  end

  always_comb begin
    state_next         = state;
    dmemRequest        = 1'b0;
    memoryStallRequest = 1'b0;
    complete           = 1'b0;
    capture            = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          dmemRequest = 1'b1;
          if (dmemGrant && is_store) complete = 1'b1;
          else begin
            memoryStallRequest = 1'b1;
            if (dmemGrant) state_next = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (dmemResponseValid) begin
          complete = 1'b1;
          capture  = 1'b1;
        end else begin
          memoryStallRequest = 1'b1;
        end
      end
      HOLD:    state_next = memoryWritebackControlStall ? HOLD : IDLE;
      DRAIN: begin
        memoryStallRequest = 1'b1;
        if (dmemResponseValid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (complete) state_next = memoryWritebackControlStall ? HOLD : IDLE;
    // A load granted in the same cycle as a flush still has a response in
    // flight, so it is drained like a flush that lands in WAIT_RESP.
    if (memoryWritebackControlFlush) begin
      case (state)
        IDLE:      state_next = (mem_op && dmemGrant && !is_store) ? DRAIN : IDLE;
        WAIT_RESP: state_next = dmemResponseValid ? IDLE : DRAIN;
        DRAIN:     state_next = dmemResponseValid ? IDLE : DRAIN;
        default:   state_next = IDLE;
      endcase
    end
  end

  assign write_out = !memoryWritebackControlFlush && !memoryWritebackControlStall &&
                     ((state == IDLE && !mem_op) || complete || state == HOLD);

  always_comb begin
    out_result = executeMemoryPayloadResult;
    if (mem_op && !is_store) out_result = (state == HOLD) ? load_data : load_ext;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      load_data <= 32'd0;
    end else begin
      state <= state_next;
      if (capture) load_data <= load_ext;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      memoryWritebackPayloadValid               <= 1'b0;
      memoryWritebackPayloadIllegal             <= 1'b0;
      memoryWritebackPayloadMemoryReadEnable    <= 1'b0;
      memoryWritebackPayloadMemoryWriteEnable   <= 1'b0;
      memoryWritebackPayloadMemoryWidth         <= 2'd0;
      memoryWritebackPayloadMemorySigned        <= 1'b0;
      memoryWritebackPayloadResult              <= 32'd0;
      memoryWritebackPayloadDestinationRegister <= 5'd0;
      memoryWritebackPayloadWritebackType       <= 2'd0;
      memoryWritebackPayloadProgramCounter      <= RESET_PC;
      memoryWritebackPayloadProgramCounterPlus4 <= 32'd0;
      memoryWritebackPayloadDestinationCSR      <= 12'd0;
      memoryWritebackPayloadOldCSRValue         <= 32'd0;
      memoryWritebackPayloadCSROp               <= 2'd0;
      memoryWritebackPayloadCSRWriteIntent      <= 1'b0;
      memoryWritebackPayloadException           <= 1'b0;
      memoryWritebackPayloadExceptionCause      <= 4'd0;
      memoryWritebackPayloadTrapValue           <= 32'd0;
    end else if (memoryWritebackControlFlush) begin
      memoryWritebackPayloadValid <= 1'b0;
    end else if (write_out) begin
      memoryWritebackPayloadValid               <= executeMemoryPayloadValid;
      memoryWritebackPayloadIllegal             <= executeMemoryPayloadIllegal;
      memoryWritebackPayloadMemoryReadEnable    <= executeMemoryPayloadMemoryReadEnable;
      memoryWritebackPayloadMemoryWriteEnable   <= executeMemoryPayloadMemoryWriteEnable;
      memoryWritebackPayloadMemoryWidth         <= executeMemoryPayloadMemoryWidth;
      memoryWritebackPayloadMemorySigned        <= executeMemoryPayloadMemorySigned;
      memoryWritebackPayloadResult              <= out_result;
      memoryWritebackPayloadDestinationRegister <= executeMemoryPayloadDestinationRegister;
      memoryWritebackPayloadWritebackType       <= executeMemoryPayloadWritebackType;
      memoryWritebackPayloadProgramCounter      <= executeMemoryPayloadProgramCounter;
      memoryWritebackPayloadProgramCounterPlus4 <= executeMemoryPayloadProgramCounterPlus4;
      memoryWritebackPayloadDestinationCSR      <= executeMemoryPayloadDestinationCSR;
      memoryWritebackPayloadOldCSRValue         <= executeMemoryPayloadOldCSRValue;
      memoryWritebackPayloadCSROp               <= executeMemoryPayloadCSROp;
      memoryWritebackPayloadCSRWriteIntent      <= executeMemoryPayloadCSRWriteIntent;
      memoryWritebackPayloadException           <= misalign_exc;
      memoryWritebackPayloadExceptionCause      <= misalign_exc ? (is_store ? 4'd6 : 4'd4) : 4'd0;
      memoryWritebackPayloadTrapValue           <= misalign_exc ? executeMemoryPayloadResult : 32'd0;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed cases plus randomized loads/stores
// checked against a word-array memory model and plain-arithmetic lane rules.
module tb_memory_access_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        em_valid, em_illegal, em_re, em_we, em_signed, em_csr_wi;
  logic [1:0]  em_width, em_wbt, em_csr_op;
  logic [31:0] em_result, em_store_data, em_pc, em_pc4, em_old_csr;
  logic [4:0]  em_rd;
  logic [11:0] em_csr;
  logic        ctrl_stall, ctrl_flush;
  logic        memoryStallRequest, dmemRequest, dmemWriteEnable;
  logic [31:0] dmemAddress, dmemWriteData, dmemReadData;
  logic [3:0]  dmemByteEnable;
  logic        dmemGrant, dmemResponseValid;
  logic        out_valid, out_illegal, out_re, out_we, out_signed, out_csr_wi, out_exc;
  logic [1:0]  out_width, out_wbt, out_csr_op, debug_state;
  logic [31:0] out_result, out_pc, out_pc4, out_old_csr, out_trap;
  logic [4:0]  out_rd;
  logic [11:0] out_csr;
  logic [3:0]  out_cause;

  memory_access_stage #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset),
    .executeMemoryPayloadValid(em_valid),
    .executeMemoryPayloadIllegal(em_illegal),
    .executeMemoryPayloadMemoryReadEnable(em_re),
    .executeMemoryPayloadMemoryWriteEnable(em_we),
    .executeMemoryPayloadMemoryWidth(em_width),
    .executeMemoryPayloadMemorySigned(em_signed),
    .executeMemoryPayloadResult(em_result),
    .executeMemoryPayloadStoreData(em_store_data),
    .executeMemoryPayloadDestinationRegister(em_rd),
    .executeMemoryPayloadWritebackType(em_wbt),
    .executeMemoryPayloadProgramCounter(em_pc),
    .executeMemoryPayloadProgramCounterPlus4(em_pc4),
    .executeMemoryPayloadDestinationCSR(em_csr),
    .executeMemoryPayloadOldCSRValue(em_old_csr),
    .executeMemoryPayloadCSROp(em_csr_op),
    .executeMemoryPayloadCSRWriteIntent(em_csr_wi),
    .memoryWritebackControlStall(ctrl_stall),
    .memoryWritebackControlFlush(ctrl_flush),
    .memoryStallRequest(memoryStallRequest),
    .dmemRequest(dmemRequest),
    .dmemWriteEnable(dmemWriteEnable),
    .dmemAddress(dmemAddress),
    .dmemWriteData(dmemWriteData),
    .dmemByteEnable(dmemByteEnable),
    .dmemGrant(dmemGrant),
    .dmemResponseValid(dmemResponseValid),
    .dmemReadData(dmemReadData),
    .memoryWritebackPayloadValid(out_valid),
    .memoryWritebackPayloadIllegal(out_illegal),
    .memoryWritebackPayloadMemoryReadEnable(out_re),
    .memoryWritebackPayloadMemoryWriteEnable(out_we),
    .memoryWritebackPayloadMemoryWidth(out_width),
    .memoryWritebackPayloadMemorySigned(out_signed),
    .memoryWritebackPayloadResult(out_result),
    .memoryWritebackPayloadDestinationRegister(out_rd),
    .memoryWritebackPayloadWritebackType(out_wbt),
    .memoryWritebackPayloadProgramCounter(out_pc),
    .memoryWritebackPayloadProgramCounterPlus4(out_pc4),
    .memoryWritebackPayloadDestinationCSR(out_csr),
    .memoryWritebackPayloadOldCSRValue(out_old_csr),
    .memoryWritebackPayloadCSROp(out_csr_op),
    .memoryWritebackPayloadCSRWriteIntent(out_csr_wi),
    .memoryWritebackPayloadException(out_exc),
    .memoryWritebackPayloadExceptionCause(out_cause),
    .memoryWritebackPayloadTrapValue(out_trap),
    .debug_state(debug_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          grant_count = 0;
  logic [31:0] mem [0:63];
  logic [31:0] exp_pc, exp_pc4, exp_old_csr, last_pc;
  logic [4:0]  exp_rd;

  always @(posedge clock) if (dmemRequest && dmemGrant) grant_count <= grant_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // reference rules
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] w, input logic sg);
    int unsigned v;
    int sh = int'(off) * 8;
    if (w >= 2) return word;
    if (w == 1) begin
      v = (word >> sh) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = (word >> sh) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] w, input logic [1:0] off);
    int v;
    if (w >= 2) return 4'hF;
    v = (w == 1 ? 3 : 1) << int'(off);
    return v[3:0];
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] w, input logic [31:0] sd);
    if (w >= 2) return sd;
    if (w == 1) return {sd[15:0], sd[15:0]};
    return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
  endfunction

  // driver tasks
  task automatic drive_payload(input logic v, il, re, we, input logic [1:0] w,
                               input logic sg, input logic [31:0] a, sd);
    em_valid = v; em_illegal = il; em_re = re; em_we = we; em_width = w;
    em_signed = sg; em_result = a; em_store_data = sd;
    em_pc = $urandom & 32'hFFFF_FFFC; em_pc4 = em_pc + 4;
    em_rd = 5'($urandom_range(0, 31)); em_old_csr = $urandom;
    em_wbt = 2'($urandom_range(0, 3)); em_csr = 12'($urandom_range(0, 4095));
    em_csr_op = 2'($urandom_range(0, 3)); em_csr_wi = 1'($urandom_range(0, 1));
    exp_pc = em_pc; exp_pc4 = em_pc4; exp_rd = em_rd; exp_old_csr = em_old_csr;
  endtask

  // kind: 0 load, 1 store, 2 alu, 3 bubble, 4 illegal load
  task automatic do_op(input int kind, input logic [1:0] w, input logic sg,
                       input logic [31:0] a, sd, input int gdelay, rlat, hold);
    logic v = (kind != 3);
    logic il = (kind == 4);
    logic re = (kind == 0 || kind == 4);
    logic we = (kind == 1);
    logic mis = (w == 1 && a[0]) || (w >= 2 && a[1:0] != 2'd0);
    logic access = v && !il && (re || we);
    logic memop = access && !mis;
    logic exc = access && mis;
    logic [3:0]  be = ref_be(w, a[1:0]);
    logic [31:0] wd = ref_wd(w, sd);
    logic [31:0] exp_res = a;
    int g0 = grant_count;
    if (memop && re) exp_res = ref_load(mem[a[7:2]], a[1:0], w, sg);
    drive_payload(v, il, re, we, w, sg, a, sd);
    if (memop) begin
      for (int i = 0; i <= gdelay; i++) begin
        dmemGrant = (i == gdelay);
        if (we && i == gdelay) ctrl_stall = (hold > 0);
        #1;
        check("req", dmemRequest, 1'b1);
        check("addr", dmemAddress, {a[31:2], 2'b00});
        check("we", dmemWriteEnable, we);
        check("be", dmemByteEnable, be);
        if (we) check("wdata", dmemWriteData, wd);
        check("stall_issue", memoryStallRequest, !(we && i == gdelay));
        step();
      end
      dmemGrant = 1'b0;
      if (re) begin
        for (int i = 0; i < rlat - 1; i++) begin
          #1;
          check("req_wait", dmemRequest, 1'b0);
          check("stall_wait", memoryStallRequest, 1'b1);
          step();
        end
        dmemResponseValid = 1'b1; dmemReadData = mem[a[7:2]]; ctrl_stall = (hold > 0);
        #1;
        check("stall_resp", memoryStallRequest, 1'b0);
        step();
        dmemResponseValid = 1'b0; dmemReadData = $urandom;
      end
      if (hold > 0) begin
        for (int i = 0; i < hold - 1; i++) begin
          #1;
          check("req_hold", dmemRequest, 1'b0);
          check("stall_hold", memoryStallRequest, 1'b0);
          check("pc_held", out_pc, last_pc);
          step();
        end
        ctrl_stall = 1'b0;
        #1;
        check("req_release", dmemRequest, 1'b0);
        check("pc_held", out_pc, last_pc);
        step();
      end
    end else begin
      ctrl_stall = 1'b0;
      #1;
      check("req_none", dmemRequest, 1'b0);
      check("stall_none", memoryStallRequest, 1'b0);
      step();
    end
    check("out_valid", out_valid, v);
    check("out_result", out_result, exp_res);
    check("out_exc", out_exc, exc);
    check("out_cause", out_cause, exc ? (we ? 4'd6 : 4'd4) : 4'd0);
    check("out_trap", out_trap, exc ? a : 32'd0);
    check("out_pc", out_pc, exp_pc);
    check("out_pc4", out_pc4, exp_pc4);
    check("out_rd", out_rd, exp_rd);
    check("out_old_csr", out_old_csr, exp_old_csr);
    check("grants", grant_count - g0, memop ? 1 : 0);
    last_pc = exp_pc;
    if (memop && we)
      for (int b = 0; b < 4; b++) if (be[b]) mem[a[7:2]][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    reset = 1'b1; ctrl_stall = 1'b0; ctrl_flush = 1'b0;
    dmemGrant = 1'b0; dmemResponseValid = 1'b0; dmemReadData = 32'd0;
    drive_payload(0, 0, 0, 0, 2'd0, 0, 32'd0, 32'd0);
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_req", dmemRequest, 1'b0);
    check("rst_stall", memoryStallRequest, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_exc", out_exc, 1'b0);
    check("rst_pc", out_pc, RST_PC);
    last_pc = RST_PC;
    step();

    // directed cases
    mem[0] = 32'hDEAD_BEEF;
    do_op(0, 2'd2, 0, 32'h100, 32'd0, 0, 2, 0);
    mem[0] = 32'h80FF_FFFF;
    do_op(0, 2'd0, 1, 32'h103, 32'd0, 0, 1, 0);
    check("sbyte_val", out_result, 32'hFFFF_FF80);
    do_op(0, 2'd0, 0, 32'h103, 32'd0, 1, 2, 0);
    check("ubyte_val", out_result, 32'h0000_0080);
    do_op(1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 0, 1, 0);
    do_op(0, 2'd2, 0, 32'h101, 32'd0, 0, 1, 0);
    check("mis_cause", out_cause, 4'd4);
    do_op(1, 2'd1, 0, 32'h33, 32'd5, 0, 1, 0);
    check("mis_store_cause", out_cause, 4'd6);
    do_op(0, 2'd2, 0, 32'h44, 32'd0, 1, 2, 3);
    do_op(1, 2'd0, 0, 32'h45, 32'h77, 0, 1, 2);

    // flush while waiting for a load response
    drive_payload(1, 0, 1, 0, 2'd2, 0, 32'h40, 32'd0);
    dmemGrant = 1'b1;
    #1 check("fl_req", dmemRequest, 1'b1);
    step();
    dmemGrant = 1'b0; ctrl_flush = 1'b1;
    #1 check("fl_stall_wait", memoryStallRequest, 1'b1);
    step();
    ctrl_flush = 1'b0;
    drive_payload(0, 0, 0, 0, 2'd0, 0, 32'd0, 32'd0);
    #1;
    check("fl_valid", out_valid, 1'b0);
    check("fl_stall_drain", memoryStallRequest, 1'b1);
    check("fl_req_drain", dmemRequest, 1'b0);
    step();
    dmemResponseValid = 1'b1; dmemReadData = $urandom;
    #1 check("fl_stall_resp", memoryStallRequest, 1'b1);
    step();
    dmemResponseValid = 1'b0;
    #1 check("fl_stall_done", memoryStallRequest, 1'b0);
    step();
    do_op(0, 2'd1, 1, 32'h46, 32'd0, 0, 2, 0);

    // flush in the same cycle as completion
    drive_payload(1, 0, 1, 0, 2'd2, 0, 32'h48, 32'd0);
    dmemGrant = 1'b1;
    #1;
    step();
    dmemGrant = 1'b0; dmemResponseValid = 1'b1; dmemReadData = mem[18]; ctrl_flush = 1'b1;
    #1;
    step();
    dmemResponseValid = 1'b0; ctrl_flush = 1'b0;
    drive_payload(0, 0, 0, 0, 2'd0, 0, 32'd0, 32'd0);
    #1;
    check("flc_valid", out_valid, 1'b0);
    check("flc_stall", memoryStallRequest, 1'b0);
    step();

    // reset while waiting for a load response
    drive_payload(1, 0, 1, 0, 2'd2, 0, 32'h4C, 32'd0);
    dmemGrant = 1'b1;
    #1;
    step();
    dmemGrant = 1'b0; reset = 1'b1;
    #1;
    step();
    reset = 1'b0;
    drive_payload(0, 0, 0, 0, 2'd0, 0, 32'd0, 32'd0);
    #1;
    check("rw_stall", memoryStallRequest, 1'b0);
    check("rw_req", dmemRequest, 1'b0);
    check("rw_valid", out_valid, 1'b0);
    check("rw_pc", out_pc, RST_PC);
    last_pc = RST_PC;
    step();

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int kind = $urandom_range(0, 9);
      int hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      kind = (kind < 4) ? 0 : (kind < 7) ? 1 : (kind < 8) ? 2 : (kind < 9) ? 3 : 4;
      do_op(kind, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom, $urandom_range(0, 2),
            $urandom_range(1, 3), hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
